pp_limb_accumulator: RTL and testbench
======================================

// Module: pp_limb_accumulator
// PURPOSE
//  Consumes the 256-bit partial-product limbs produced by the parallel multiplier
//  stage of the 1024-bit large multiplier. Accumulates each limb at its position
//  in a 2048-bit result, normalises the carries, then streams out the final
//  product one limb per beat, with valid/ready on both sides.
// PARAMETERS
//  LIMB_W   256  width of one partial-product / output limb
//  N_LIMBS  8    limbs in the result (8*256 = 2048 bits)
//  IDX_W    3    limb index width, clog2(N_LIMBS)
//  CW       8    per-limb carry counter width
// PORTS
//  clk       in   1        single clock, all logic on rising edge
//  resetn    in   1        asynchronous, active-HIGH reset (1 = reset)
//  in_valid  in   1        partial-product beat present
//  in_ready  out  1        stage accepts a beat (IDLE or ACCUM)
//  in_data   in   LIMB_W   partial-product limb value
//  in_idx    in   IDX_W    limb position of in_data (0 = least significant)
//  in_last   in   1        final beat of this product
//  out_valid out  1        result limb present
//  out_ready in   1        downstream accepts result limb
//  out_data  out  LIMB_W   normalised result limb
//  out_idx   out  IDX_W    position of out_data, 0..N_LIMBS-1 ascending
//  out_last  out  1        high with out_idx == N_LIMBS-1
//  busy      out  1        state != IDLE
//  overflow  out  1        sticky error flag; cleared when the next job starts
// BEHAVIOUR
//  Reset: state=IDLE; acc[*]=0; c[*]=0; in_ready=1; out_valid=0; out_data=0;
//   out_idx=0; out_last=0; busy=0; overflow=0. Reset mid-job discards the job.
//  Handshake: a transfer occurs when valid&&ready are both high at a clock edge.
//   out_data, out_idx and out_last stay stable while out_valid&&!out_ready.
//  FSM:
//   IDLE : in_ready=1. First accepted beat clears overflow, accumulates that beat,
//          and moves to ACCUM. If in_last is set on that beat, moves to NORM.
//   ACCUM: in_ready=1. Each beat does {c[i],acc[i]} += in_data with i=in_idx.
//          The in_last beat is accumulated, then the FSM moves to NORM.
//   NORM : in_ready=0. One limb per cycle, i=0..N_LIMBS-1, with pend (CW+1 bits)
//          initialised to 0:
//          t=acc[i]+pend; acc[i]=t[LIMB_W-1:0]; pend=c[i]+t[LIMB_W]; c[i]=0.
//          After i=N_LIMBS-1: if pend!=0, set overflow. Then go to DRAIN.
//   DRAIN: in_ready=0, out_valid=1. Emits acc[0..N_LIMBS-1] in order.
//          The out_last handshake clears acc[*], drops out_valid and returns to IDLE.
//  Latency: in_last accepted at edge T; NORM occupies T+1..T+N_LIMBS;
//   out_valid rises after edge T+N_LIMBS+1. The first output beat is at T+9
//   with default parameters.
//  Boundaries:
//   - in_idx >= N_LIMBS: data is dropped and overflow is set. in_last still
//     takes effect.
//   - Carry counter c[i] saturating at 2^CW-1: c[i] holds and overflow is set.
//   - in_valid while in_ready=0: ignored, no state change.
//   - Output value is the true sum mod 2^(LIMB_W*N_LIMBS).
// TESTING
//  1 one beat idx0=5, last -> 8 beats: limb0=5, limbs1..7=0, out_last on idx7;
//    first out_valid 9 cycles after the in_last edge.
//  2 idx0=all-ones, then idx0=1 last -> limb0=0, limb1=1, rest 0, overflow=0.
//  3 idx0..6=all-ones, then idx0=1 last -> limbs0..6=0, limb7=1 (full ripple).
//  4 idx7=all-ones twice, last -> limb7=all-ones-1, overflow=1. The next job's
//    first beat clears overflow.
//  5 out_ready low 3 cycles at idx3 of DRAIN -> out_data/out_idx held at limb3;
//    no beat lost or duplicated.
//  6 assert resetn during DRAIN at idx4 -> out_valid=0 immediately (async).
//    After release in_ready=1, and case 1 rerun is correct.

Source files
------------

// File: rtl/pp_limb_accumulator_if.sv
// pp_limb_accumulator_if: handshake bundle between the multiplier stage, the accumulator and its result consumer.
//   in_*      partial-product limb stream (valid/ready, data, index, last)
//   out_*     normalised result limb stream (valid/ready, data, index, last)
//   busy      accumulator is not idle
//   overflow  sticky error flag of the current/last job
interface pp_limb_accumulator_if #(
    parameter int LIMB_W = 256,
    parameter int IDX_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [LIMB_W-1:0] in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;
    logic              overflow;

    modport master (
        output in_valid, in_data, in_idx, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy, overflow
    );

    modport slave (
        input  in_valid, in_data, in_idx, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy, overflow
    );
endinterface

// File: rtl/pp_limb_accumulator.sv
// pp_limb_accumulator: accumulates partial-product limbs into a multi-limb result, normalises carries, streams the product out.
//   clk     rising-edge clock
//   resetn  asynchronous reset, active high (1 = reset)
//   bus     pp_limb_accumulator_if slave: input limb stream, output limb stream, busy, overflow
module pp_limb_accumulator #(
    parameter int LIMB_W  = 256,
    parameter int N_LIMBS = 8,
    parameter int IDX_W   = 3,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic resetn,
    pp_limb_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, NORM, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [LIMB_W-1:0] acc_q [N_LIMBS];
    logic [LIMB_W-1:0] acc_d [N_LIMBS];
    logic [CW-1:0]     c_q   [N_LIMBS];
    logic [CW-1:0]     c_d   [N_LIMBS];
    logic [CW:0]       pend_q, pend_d;
    // NORM walks cnt 0..N_LIMBS (the extra step is the final pend check); DRAIN reuses it as the output index
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [LIMB_W:0]   sum, t;
    logic [IDX_W-1:0]  ni;
    logic              in_range, take_in, take_out;

    assign ni            = cnt_q[IDX_W-1:0];
    assign in_range      = {1'b0, bus.in_idx} < (IDX_W+1)'(N_LIMBS);
    assign bus.in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign bus.out_valid = state_q == DRAIN;
    assign bus.out_idx   = ni;
    assign bus.out_data  = acc_q[ni];
    assign bus.out_last  = bus.out_valid && (ni == IDX_W'(N_LIMBS - 1));
    assign bus.busy      = state_q != IDLE;
    assign bus.overflow  = ovf_q;
    assign take_in       = bus.in_valid && bus.in_ready;
    assign take_out      = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        c_d     = c_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum     = {1'b0, acc_q[bus.in_idx]} + {1'b0, bus.in_data};
        t       = {1'b0, acc_q[ni]} + (LIMB_W+1)'(pend_q);
        case (state_q)
            IDLE, ACCUM: begin
                if (take_in) begin
                    if (state_q == IDLE)
                        ovf_d = 1'b0;
                    if (!in_range)
                        ovf_d = 1'b1;
                    else begin
                        acc_d[bus.in_idx] = sum[LIMB_W-1:0];
                        // a saturated carry counter cannot represent the carry, so the result is wrong
                        if (sum[LIMB_W] && (&c_q[bus.in_idx]))
                            ovf_d = 1'b1;
                        else if (sum[LIMB_W])
                            c_d[bus.in_idx] = c_q[bus.in_idx] + CW'(1);
                    end
                    state_d = bus.in_last ? NORM : ACCUM;
                    cnt_d   = '0;
                    pend_d  = '0;
                end
            end
            NORM: begin
                if (cnt_q[IDX_W]) begin
                    // carry out of the top limb means the product exceeded the result width
                    if (pend_q != '0)
                        ovf_d = 1'b1;
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    acc_d[ni] = t[LIMB_W-1:0];
                    pend_d    = (CW+1)'(c_q[ni]) + (CW+1)'(t[LIMB_W]);
                    c_d[ni]   = '0;
                    cnt_d     = cnt_q + (IDX_W+1)'(1);
                end
            end
            DRAIN: begin
                if (take_out && bus.out_last) begin
                    acc_d   = '{default: '0};
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (take_out)
                    cnt_d = cnt_q + (IDX_W+1)'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
            acc_q   <= '{default: '0};
            c_q     <= '{default: '0};
            pend_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pp_limb_accumulator.sv
// tb_pp_limb_accumulator: directed self-checking bench for pp_limb_accumulator.
module tb_pp_limb_accumulator;
    localparam int LW = 256;
    localparam logic [LW-1:0] ONES = '1;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [LW-1:0] exp_l [8];

    pp_limb_accumulator_if #(.LIMB_W(LW), .IDX_W(3)) bus ();

    pp_limb_accumulator #(.LIMB_W(LW), .N_LIMBS(8), .IDX_W(3), .CW(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_exp();
        for (int i = 0; i < 8; i++)
            exp_l[i] = '0;
    endtask

    task automatic send(input logic [LW-1:0] d, input logic [2:0] i, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_idx   = i;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // consumes output beats against exp_l; stalls 3 cycles at beat stall_at; returns without consuming at beat stop_at
    task automatic drain(input int stall_at, input int stop_at);
        int n;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(n);
            checks++;
            if (!bus.out_valid) begin
                errors++;
                $display("FAIL drain_timeout beat %0d out_valid=%0b required 1", i, bus.out_valid);
                return;
            end
            if (i == stop_at)
                return;
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(i) || bus.out_data !== exp_l[i]) begin
                        errors++;
                        $display("FAIL stall_hold valid=%0b idx=%0d data=%h required 1/%0d/%h",
                                 bus.out_valid, bus.out_idx, bus.out_data, i, exp_l[i]);
                    end
                end
                bus.out_ready = 1'b1;
            end
            checks++;
            if (bus.out_idx !== 3'(i)) begin
                errors++;
                $display("FAIL out_idx got %0d required %0d", bus.out_idx, i);
            end
            checks++;
            if (bus.out_data !== exp_l[i]) begin
                errors++;
                $display("FAIL out_data[%0d] got %h required %h", i, bus.out_data, exp_l[i]);
            end
            checks++;
            if (bus.out_last !== (i == 7)) begin
                errors++;
                $display("FAIL out_last[%0d] got %0b required %0b", i, bus.out_last, i == 7);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_end valid/busy/in_ready got %0b%0b%0b required 001",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_idx !== 3'd0 ||
            bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%0b vld=%0b data=%h idx=%0d last=%0b busy=%0b ovf=%0b required 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy, bus.overflow);
        end
    endtask

    task automatic test_single();
        int n;
        clear_exp();
        exp_l[0] = LW'(5);
        send(LW'(5), 3'd0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_busy busy=%0b in_ready=%0b required 1 0", bus.busy, bus.in_ready);
        end
        wait_valid(n);
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL latency got %0d cycles required 9", n);
        end
        drain(-1, -1);
    endtask

    task automatic test_carry();
        clear_exp();
        exp_l[1] = LW'(1);
        send(ONES, 3'd0, 1'b0);
        send(LW'(1), 3'd0, 1'b1);
        drain(-1, -1);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL carry_overflow got %0b required 0", bus.overflow);
        end
    endtask

    task automatic test_ripple();
        clear_exp();
        exp_l[7] = LW'(1);
        for (int i = 0; i < 7; i++)
            send(ONES, 3'(i), 1'b0);
        send(LW'(1), 3'd0, 1'b1);
        drain(-1, -1);
    endtask

    task automatic test_overflow();
        clear_exp();
        exp_l[7] = ONES - LW'(1);
        send(ONES, 3'd7, 1'b0);
        send(ONES, 3'd7, 1'b1);
        drain(-1, -1);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got %0b required 1", bus.overflow);
        end
        clear_exp();
        exp_l[0] = LW'(5);
        send(LW'(5), 3'd0, 1'b1);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %0b required 0", bus.overflow);
        end
        drain(-1, -1);
    endtask

    task automatic load_pattern();
        clear_exp();
        for (int i = 0; i < 8; i++) begin
            exp_l[i] = LW'(i * 17 + 3) | (LW'(i + 1) << 200);
            send(exp_l[i], 3'(i), i == 7);
        end
    endtask

    task automatic test_backpressure();
        load_pattern();
        drain(3, -1);
    endtask

    task automatic test_reset_mid();
        load_pattern();
        drain(-1, 4);
        checks++;
        if (bus.out_idx !== 3'd4) begin
            errors++;
            $display("FAIL reset_mid_pos idx got %0d required 4", bus.out_idx);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%0b busy=%0b required 0 0", bus.out_valid, bus.busy);
        end
        @(posedge clk);
        #1;
        resetn = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL after_reset in_ready=%0b out_data=%h required 1 0", bus.in_ready, bus.out_data);
        end
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_ripple();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
